// File: rtl/transform_pkg.sv
// Shared types and default widths for the transform line scheduler.
package transform_pkg;

  localparam int unsigned DefWWidth  = 10;
  localparam int unsigned DefKWidth  = 4;
  localparam int unsigned DefSWidth  = 2;
  localparam int unsigned DefPWidth  = 2;
  localparam int unsigned StallWidth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StRowEnd,
    StDone
  } sched_state_e;

endpackage

// File: rtl/transform_row_map.sv
// Maps (output row, kernel tap) to an input row and flags taps that fall in the padding.
module transform_row_map
  import transform_pkg::*;
#(
  parameter int unsigned C_W_WIDTH = DefWWidth,
  parameter int unsigned C_KWIDTH  = DefKWidth,
  parameter int unsigned C_SWIDTH  = DefSWidth,
  parameter int unsigned C_PWIDTH  = DefPWidth
) (
  input  logic [C_W_WIDTH-1:0] oh,
  input  logic [C_KWIDTH-1:0]  kh,
  input  logic [C_SWIDTH-1:0]  stride,
  input  logic [C_PWIDTH-1:0]  pad,
  input  logic [C_W_WIDTH-1:0] iheight,
  output logic                 in_range,
  output logic [C_W_WIDTH-1:0] idx
);

  localparam int unsigned HW = C_W_WIDTH + 2;

  logic [HW-1:0] stride_eff;
  logic [HW-1:0] hidx;

  // Two's-complement row index; the top bit is the sign of oh*stride + kh - pad.
  always_comb begin
    stride_eff = (stride == '0) ? HW'(1) : HW'(stride);
    hidx       = HW'(oh) * stride_eff + HW'(kh) - HW'(pad);
  end

  assign in_range = ~hidx[HW-1] && (hidx < HW'(iheight));
  assign idx      = hidx[C_W_WIDTH-1:0];

endmodule

// File: rtl/transform_line_sched.sv
// Vertical line-fetch scheduler for a windowed transform: one beat per (row, tap).
// Optional stall counter enabled by defining TRANSFORM_LINE_SCHED_STATS_EN.
module transform_line_sched
  import transform_pkg::*;
#(
  parameter int unsigned C_W_WIDTH = DefWWidth,
  parameter int unsigned C_KWIDTH  = DefKWidth,
  parameter int unsigned C_SWIDTH  = DefSWidth,
  parameter int unsigned C_PWIDTH  = DefPWidth
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_ap_start,
  input  logic [C_W_WIDTH-1:0]  I_iheight,
  input  logic [C_W_WIDTH-1:0]  I_oheight,
  input  logic [C_KWIDTH-1:0]   I_kernel_h,
  input  logic [C_SWIDTH-1:0]   I_stride_h,
  input  logic [C_PWIDTH-1:0]   I_pad_h,
  output logic                  O_line_req,
  input  logic                  I_line_ack,
  output logic [C_W_WIDTH-1:0]  O_line_idx,
  output logic                  O_pad_line,
  output logic [C_KWIDTH-1:0]   O_kh,
  output logic                  O_row_done,
  output logic                  O_busy,
  output logic                  O_ap_done,
  output logic [StallWidth-1:0] O_stall_cycles
);

  sched_state_e st_q;
  logic start_q, start_rise, zero_job, last_tap, last_row, launch;

  logic [C_W_WIDTH-1:0] ih_q, ohgt_q, oh_q;
  logic [C_KWIDTH-1:0]  kern_q, kh_q;
  logic [C_SWIDTH-1:0]  stride_q;
  logic [C_PWIDTH-1:0]  padc_q;

  logic [C_W_WIDTH-1:0] map_oh, map_ih, map_idx;
  logic [C_KWIDTH-1:0]  map_kh;
  logic [C_SWIDTH-1:0]  map_stride;
  logic [C_PWIDTH-1:0]  map_pad;
  logic                 map_in_range;

  assign start_rise = I_ap_start & ~start_q;
  assign zero_job   = (I_oheight == '0) || (I_kernel_h == '0);
  assign last_tap   = (kh_q == kern_q - C_KWIDTH'(1));
  assign last_row   = (oh_q == ohgt_q);

  // The row map looks one beat ahead so each beat is registered as its state is entered.
  always_comb begin
    map_oh     = oh_q;
    map_kh     = kh_q + C_KWIDTH'(1);
    map_ih     = ih_q;
    map_stride = stride_q;
    map_pad    = padc_q;
    case (st_q)
      StIdle: begin
        map_oh     = '0;
        map_kh     = '0;
        map_ih     = I_iheight;
        map_stride = I_stride_h;
        map_pad    = I_pad_h;
      end
      StRowEnd: map_kh = '0;
      default: ;
    endcase
  end

  always_comb begin
    case (st_q)
      StIdle:    launch = start_rise & ~zero_job;
      StIssue:   launch = ~last_tap;
      StWaitAck: launch = I_line_ack & ~last_tap;
      StRowEnd:  launch = ~last_row;
      default:   launch = 1'b0;
    endcase
  end

  transform_row_map #(
    .C_W_WIDTH (C_W_WIDTH),
    .C_KWIDTH  (C_KWIDTH),
    .C_SWIDTH  (C_SWIDTH),
    .C_PWIDTH  (C_PWIDTH)
  ) u_row_map (
    .oh       (map_oh),
    .kh       (map_kh),
    .stride   (map_stride),
    .pad      (map_pad),
    .iheight  (map_ih),
    .in_range (map_in_range),
    .idx      (map_idx)
  );

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      st_q       <= StIdle;
      start_q    <= 1'b1;  // a level already high at release is not an edge
      ih_q       <= '0;
      ohgt_q     <= '0;
      kern_q     <= '0;
      stride_q   <= '0;
      padc_q     <= '0;
      oh_q       <= '0;
      kh_q       <= '0;
      O_line_req <= 1'b0;
      O_line_idx <= '0;
      O_pad_line <= 1'b0;
      O_kh       <= '0;
      O_row_done <= 1'b0;
      O_busy     <= 1'b0;
      O_ap_done  <= 1'b0;
    end else begin
      start_q    <= I_ap_start;
      O_pad_line <= 1'b0;
      O_row_done <= 1'b0;
      O_ap_done  <= 1'b0;
      case (st_q)
        StIdle: begin
          if (start_rise) begin
            ih_q     <= I_iheight;
            ohgt_q   <= I_oheight;
            kern_q   <= I_kernel_h;
            stride_q <= I_stride_h;
            padc_q   <= I_pad_h;
            oh_q     <= '0;
            kh_q     <= '0;
            O_busy   <= 1'b1;
            if (zero_job) st_q <= StDone;
          end
        end
        StIssue, StWaitAck: begin
          if (st_q == StIssue || I_line_ack) begin
            O_line_req <= 1'b0;
            if (last_tap) begin
              st_q       <= StRowEnd;
              O_row_done <= 1'b1;
              kh_q       <= '0;
              oh_q       <= oh_q + C_W_WIDTH'(1);
            end
          end
        end
        StRowEnd: if (last_row) st_q <= StDone;
        StDone: begin
          O_ap_done <= 1'b1;
          O_busy    <= 1'b0;
          st_q      <= StIdle;
        end
        default: st_q <= StIdle;
      endcase
      if (launch) begin
        kh_q <= map_kh;
        O_kh <= map_kh;
        if (map_in_range) begin
          O_line_req <= 1'b1;
          O_line_idx <= map_idx;
          st_q       <= StWaitAck;
        end else begin
          O_pad_line <= 1'b1;
          st_q       <= StIssue;
        end
      end
    end
  end

`ifdef TRANSFORM_LINE_SCHED_STATS_EN
  logic [StallWidth-1:0] stall_q;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      stall_q <= '0;
    end else if (st_q == StIdle && start_rise) begin
      stall_q <= '0;
    end else if (st_q == StWaitAck && !I_line_ack && stall_q != {StallWidth{1'b1}}) begin
      stall_q <= stall_q + StallWidth'(1);
    end
  end

  assign O_stall_cycles = stall_q;
`else
  assign O_stall_cycles = '0;
`endif

endmodule
